uart_rx_rtl: RTL and testbench
==============================

UART_RX_RTL -- requirements
Module: uart_rx_rtl

Interface
REQ-001 The block SHALL have parameter B_PER_T, default 8, giving data bits per frame.
REQ-002 The block SHALL have parameter BR, default 9600, giving the baud rate in bit/s.
REQ-003 The block SHALL have parameter CLK_FREQ, default 50_000_000, giving the system clock in Hz.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port i_rx, input, 1 bit: serial line, asynchronous to i_clk, idle high.
REQ-007 The block SHALL have port o_data, output, B_PER_T bits: last received word.
REQ-008 The block SHALL have port o_dv, output, 1 bit: one-cycle pulse marking o_data valid.
REQ-009 The block SHALL have port o_frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.
REQ-010 The block SHALL have port o_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 The block SHALL define BAUD_TICKS = CLK_FREQ/BR (integer division) and HALF_TICKS = (BAUD_TICKS-1)/2.
REQ-012 The block SHALL stop elaboration with an error when BAUD_TICKS < 4.
REQ-013 The block SHALL pass i_rx through a 2-flop synchronizer (reset value 1) and use only the synchronized value, rx_s.
REQ-014 The tick counter SHALL be $clog2(BAUD_TICKS) bits wide and the bit index $clog2(B_PER_T) bits wide (minimum 1 bit each).
REQ-015 FSM states SHALL be IDLE, START, DATA_BITS, STOP and RECOVER.
REQ-016 IDLE SHALL clear the counter and go to START on the first cycle rx_s=0.
REQ-017 START SHALL count to HALF_TICKS; at that point it SHALL go to DATA_BITS with the counter cleared if rx_s=0, else return to IDLE (glitch reject, no output pulse).
REQ-018 DATA_BITS SHALL sample rx_s each time the counter reaches BAUD_TICKS-1, then clear the counter.
REQ-019 Data SHALL be shifted in LSB first; after bit B_PER_T-1 is sampled the FSM SHALL go to STOP.
REQ-020 STOP SHALL sample rx_s when the counter reaches BAUD_TICKS-1.
REQ-021 In STOP, if the sample is 1, the block SHALL update o_data, pulse o_dv for exactly one cycle on the next clock, and go to IDLE.
REQ-022 In STOP, if the sample is 0, the block SHALL pulse o_frame_err for one cycle, leave o_data unchanged, and go to RECOVER.
REQ-023 RECOVER SHALL wait for rx_s=1 and then go to IDLE, so a break condition yields exactly one o_frame_err.
REQ-024 o_dv and o_frame_err SHALL never be high in the same cycle.
REQ-025 o_data SHALL hold its value until the next good frame; no consumer handshake exists and no backpressure is provided.
REQ-026 A start bit arriving immediately after the stop sample (back-to-back frames) SHALL be received with no lost frame.
REQ-027 An i_rx change within the tick of a sample point MAY be missed; receiver tolerance is ±(HALF_TICKS/(10·BAUD_TICKS)).

Reset
REQ-028 While i_rst_n=0: state=IDLE, counters=0, shift register=0, o_data=0, o_dv=0, o_frame_err=0, o_busy=0, synchronizer flops=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately with no pulse; after release the FSM SHALL wait in IDLE for the next low on rx_s.

Structure
REQ-030 FSM state encodings and the BAUD_TICKS/HALF_TICKS calculation SHALL live in a shared header, uart_defs, also used by uart_tx_rtl.
REQ-031 The synchronizer SHALL be a separate sub-module, uart_sync_2ff, with ports i_clk, i_rst_n, i_d and o_q.

Verification (CLK_FREQ=1_000_000, BR=100_000, so BAUD_TICKS=10)
REQ-032 Frame 0xA5 with a good stop bit -> o_data=0xA5, one o_dv pulse within 2+5+80+10+1 cycles of the start edge, o_frame_err=0.
REQ-033 i_rx low for 3 cycles, then high -> FSM returns to IDLE, with no o_dv and no o_frame_err.
REQ-034 Frame 0x3C with stop bit 0 and line held low for 50 cycles -> one o_frame_err pulse, o_data unchanged, o_busy high until the line returns high.
REQ-035 Back-to-back frames 0x00 then 0xFF with no idle gap -> two o_dv pulses, carrying 0x00 then 0xFF.
REQ-036 i_rst_n pulsed low during bit 4 of a frame, then a clean 0x5A frame -> no pulse from the aborted frame; o_data=0x5A on one o_dv pulse.

Source files
------------

// File: rtl/uart_defs.sv
// uart_defs: state encodings and baud timing shared by the UART receiver and transmitter
package uart_defs;

    typedef enum logic [2:0] {IDLE, START, DATA_BITS, STOP, RECOVER} uart_state_e;

    function automatic int baud_ticks(input int clk_freq, input int br);
        return clk_freq / br;
    endfunction

    function automatic int half_ticks(input int clk_freq, input int br);
        return (baud_ticks(clk_freq, br) - 1) / 2;
    endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// uart_sync_2ff: two-flop synchronizer, resets to the idle-high line level
module uart_sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);
    logic s1_q, s2_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= i_d;
            s2_q <= s1_q;
        end
    end

    assign o_q = s2_q;
endmodule

// File: rtl/uart_rx_rtl.sv
// uart_rx_rtl: UART receiver, LSB first, one stop bit, mid-bit sampling
// with glitch rejection on the start bit and a single error pulse per break.
module uart_rx_rtl
    import uart_defs::*;
#(
    parameter int B_PER_T  = 8,
    parameter int BR       = 9600,
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_rx,
    output logic [B_PER_T-1:0] o_data,
    output logic               o_dv,
    output logic               o_frame_err,
    output logic               o_busy
);
    localparam int BAUD_TICKS = baud_ticks(CLK_FREQ, BR);
    localparam int HALF_TICKS = half_ticks(CLK_FREQ, BR);
    localparam int CW = (BAUD_TICKS > 1) ? $clog2(BAUD_TICKS) : 1;
    localparam int BW = (B_PER_T > 1) ? $clog2(B_PER_T) : 1;

    if (BAUD_TICKS < 4) begin : g_baud_check
        $error("uart_rx_rtl: CLK_FREQ/BR must be at least 4");
    end

    logic rx_s;

    uart_sync_2ff u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_rx),
        .o_q    (rx_s)
    );

    uart_state_e        state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [BW-1:0]      idx_q, idx_d;
    logic [B_PER_T-1:0] sh_q, sh_d, data_q, data_d;
    logic               dv_q, dv_d, ferr_q, ferr_d;

    wire half_hit = cnt_q == CW'(HALF_TICKS);
    wire baud_hit = cnt_q == CW'(BAUD_TICKS - 1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d   = '0;
                state_d = rx_s ? IDLE : START;
            end
            START: if (half_hit) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s ? IDLE : DATA_BITS;
            end
            DATA_BITS: if (baud_hit) begin
                cnt_d   = '0;
                sh_d    = (sh_q >> 1) | (B_PER_T'(rx_s) << (B_PER_T - 1));
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == BW'(B_PER_T - 1)) ? STOP : DATA_BITS;
            end
            STOP: if (baud_hit) begin
                cnt_d   = '0;
                data_d  = rx_s ? sh_q : data_q;
                dv_d    = rx_s;
                ferr_d  = !rx_s;
                state_d = rx_s ? IDLE : RECOVER;
            end
            RECOVER: begin
                cnt_d   = '0;
                state_d = rx_s ? IDLE : RECOVER;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_data      = data_q;
    assign o_dv        = dv_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_rtl.sv
// tb_uart_rx_rtl: drives serial frames at 10 clocks per bit and checks the
// received words and error pulses against a queue of what was sent.
module tb_uart_rx_rtl;
    localparam int BT = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       dv, ferr, busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int dv_cyc = 0;
    int nferr = 0;
    logic [7:0] got[$];

    uart_rx_rtl #(.B_PER_T(8), .BR(100_000), .CLK_FREQ(1_000_000)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx       (rx),
        .o_data     (data),
        .o_dv       (dv),
        .o_frame_err(ferr),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rst_n) begin
        if (dv) begin
            got.push_back(data);
            dv_cyc = cyc;
        end
        if (ferr) nferr++;
        if (dv && ferr) begin
            total++;
            bad++;
            $display("FAIL dv_ferr_overlap got dv=%b ferr=%b exp not both", dv, ferr);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        wait_cyc(BT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_cyc(BT);
        end
        rx = stop;
        wait_cyc(BT);
    endtask

    task automatic clear_log();
        got.delete();
        nferr = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        wait_cyc(3);
        total++;
        if ({data, dv, ferr, busy} !== 11'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0", {data, dv, ferr, busy});
        end
        rst_n = 1'b1;
        wait_cyc(5);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_good_frame();
        int c0;
        clear_log();
        c0 = cyc;
        send_frame(8'hA5, 1'b1);
        wait_cyc(5);
        total++;
        if (got.size() != 1 || got[0] !== 8'hA5) begin
            bad++;
            $display("FAIL good_frame got n=%0d w=%h exp n=1 w=a5", got.size(), got.size() ? got[0] : 8'hxx);
        end
        total++;
        if (dv_cyc - c0 > 98 || dv_cyc - c0 < 1) begin
            bad++;
            $display("FAIL good_latency got=%0d exp<=98", dv_cyc - c0);
        end
        total++;
        if (nferr != 0) begin
            bad++;
            $display("FAIL good_ferr got=%0d exp=0", nferr);
        end
    endtask

    task automatic test_glitch();
        clear_log();
        rx = 1'b0;
        wait_cyc(3);
        rx = 1'b1;
        wait_cyc(20);
        total++;
        if (got.size() != 0 || nferr != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL glitch got dv=%0d ferr=%0d busy=%b exp 0 0 0", got.size(), nferr, busy);
        end
    endtask

    task automatic test_frame_error();
        logic [7:0] prev;
        int busy_low;
        clear_log();
        prev = data;
        busy_low = 0;
        send_frame(8'h3C, 1'b0);
        for (int i = 0; i < 40; i++) begin
            wait_cyc(1);
            if (busy !== 1'b1) busy_low++;
        end
        total++;
        if (busy_low != 0) begin
            bad++;
            $display("FAIL break_busy got low_cycles=%0d exp=0", busy_low);
        end
        rx = 1'b1;
        wait_cyc(8);
        total++;
        if (nferr != 1 || got.size() != 0) begin
            bad++;
            $display("FAIL frame_err got ferr=%0d dv=%0d exp 1 0", nferr, got.size());
        end
        total++;
        if (data !== prev) begin
            bad++;
            $display("FAIL frame_err_data got=%h exp=%h", data, prev);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL break_release got busy=%b exp 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        wait_cyc(5);
        total++;
        if (got.size() != 2) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=2", got.size());
        end else begin
            total++;
            if (got[0] !== 8'h00 || got[1] !== 8'hFF) begin
                bad++;
                $display("FAIL b2b_data got=%h,%h exp=00,ff", got[0], got[1]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        clear_log();
        d = 8'h00;
        rx = 1'b0;
        wait_cyc(BT);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            wait_cyc(BT);
        end
        wait_cyc(4);
        rst_n = 1'b0;
        wait_cyc(1);
        total++;
        if (busy !== 1'b0 || dv !== 1'b0 || ferr !== 1'b0) begin
            bad++;
            $display("FAIL reset_abort got busy=%b dv=%b ferr=%b exp 0", busy, dv, ferr);
        end
        rx = 1'b1;
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(30);
        send_frame(8'h5A, 1'b1);
        wait_cyc(5);
        total++;
        if (got.size() != 1 || nferr != 0 || data !== 8'h5A) begin
            bad++;
            $display("FAIL reset_then_frame got n=%0d ferr=%0d data=%h exp 1 0 5a", got.size(), nferr, data);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int exp_ferr;
        logic [7:0] d;
        logic stop;
        int gap;
        clear_log();
        exp_ferr = 0;
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(d, stop);
            if (stop) exp_q.push_back(d);
            else exp_ferr++;
            rx = 1'b1;
            gap = stop ? $urandom_range(0, 15) : $urandom_range(3, 15);
            wait_cyc(gap);
        end
        wait_cyc(20);
        total++;
        if (nferr != exp_ferr) begin
            bad++;
            $display("FAIL rand_ferr got=%0d exp=%0d", nferr, exp_ferr);
        end
        total++;
        if (got.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_count got=%0d exp=%0d", got.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                total++;
                if (got[i] !== exp_q[i]) begin
                    bad++;
                    $display("FAIL rand_word[%0d] got=%h exp=%h", i, got[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
